// File: rtl/connect_arb_pkg.sv
// Shared types, flit field positions and sizing helpers for the injection-port arbiter.
`ifndef FLIT_BUFFER_DEPTH
`define FLIT_BUFFER_DEPTH 4
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef VC_BITS
`define VC_BITS 1
`endif

package connect_arb_pkg;

    // Field positions for a default-width flit: valid in the MSB, tail right below it.
    localparam int FLIT_VALID_IDX = `FLIT_WIDTH - 1;
    localparam int FLIT_TAIL_IDX  = `FLIT_WIDTH - 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // One extra bit so the counter can hold the full buffer depth.
    function automatic int cred_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or above ptr wins, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          any
);

    logic [N-1:0]   mask_lo;
    logic [2*N-1:0] dbl;

    // Lower copy keeps only requesters at/above ptr; upper copy covers the wrap-around.
    always_comb begin
        mask_lo = '0;
        for (int i = 0; i < N; i++) begin
            mask_lo[i] = (IW'(i) >= ptr);
        end
        dbl    = {req, req & mask_lo};
        any    = 1'b0;
        gnt_id = '0;
        for (int j = 0; j < 2 * N; j++) begin
            if (!any && dbl[j]) begin
                any    = 1'b1;
                gnt_id = (j >= N) ? IW'(j - N) : IW'(j);
            end
        end
        gnt = '0;
        if (any) begin
            gnt[gnt_id] = 1'b1;
        end
    end

endmodule

// File: rtl/inport_arbiter.sv
// Packet-granular round-robin sharing of one router injection port, with credit flow control.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ARB_IDLE   | no packet in flight; rr_arbiter picks the winner from rr_ptr
// ARB_LOCKED | owner_q has sent a head flit; port held until its tail fires
`ifndef FLIT_BUFFER_DEPTH
`define FLIT_BUFFER_DEPTH 4
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef VC_BITS
`define VC_BITS 1
`endif

module inport_arbiter
    import connect_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DEPTH  = `FLIT_BUFFER_DEPTH,
    parameter int FLIT_W = `FLIT_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [N_REQ*FLIT_W-1:0]  req_flit,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    output logic [FLIT_W-1:0]        send_ports_putFlit_flit_in,
    output logic                     EN_send_ports_putFlit,
    input  logic [`VC_BITS:0]        send_ports_getCredits,
    output logic                     EN_send_ports_getCredits,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     locked,
    output logic                     credit_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = cred_w(DEPTH);
    // Tail sits directly below the valid bit whatever the flit width.
    localparam int TAIL_IDX = FLIT_W - 1 - (FLIT_VALID_IDX - FLIT_TAIL_IDX);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] last_gnt_q, last_gnt_d;
    logic [CW-1:0] credits_q, credits_d;
    logic          credit_err_q, credit_err_d;

    logic [N_REQ-1:0]  arb_gnt;
    logic [IW-1:0]     arb_id;
    logic              arb_any;
    logic [N_REQ-1:0]  winner_oh;
    logic [IW-1:0]     winner_id;
    logic              winner_vld;
    logic [FLIT_W-1:0] winner_flit;
    logic              winner_tail;
    logic              cred_ok;
    logic              cr_in;
    logic              fire;
    logic              unused_bits;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    // While locked the owner is the only candidate; other requesters are ignored.
    always_comb begin
        winner_id  = arb_id;
        winner_vld = arb_any;
        winner_oh  = arb_gnt;
        if (state_q == ARB_LOCKED) begin
            winner_id            = owner_q;
            winner_vld           = req_valid[owner_q];
            winner_oh            = '0;
            winner_oh[owner_q]   = 1'b1;
        end
    end

    // Select the winner's flit slice.
    always_comb begin
        winner_flit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner_id == IW'(i)) begin
                winner_flit = req_flit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    assign winner_tail = winner_flit[TAIL_IDX];
    assign cred_ok     = (credits_q != '0);
    assign cr_in       = send_ports_getCredits[`VC_BITS];
    assign fire        = RST_N && winner_vld && cred_ok;
    // Requester valid bit and the VC index of returned credits carry no information here.
    assign unused_bits = &{1'b0, winner_flit[FLIT_W-1], send_ports_getCredits};

    assign req_ready                  = (RST_N && cred_ok) ? winner_oh : '0;
    assign EN_send_ports_putFlit      = fire;
    assign send_ports_putFlit_flit_in = fire ? {1'b1, winner_flit[FLIT_W-2:0]} : '0;
    assign EN_send_ports_getCredits   = 1'b1;
    assign locked                     = (state_q == ARB_LOCKED);
    assign grant_id   = ((state_q == ARB_LOCKED) || arb_any) ? winner_id : last_gnt_q;
    assign credit_err = credit_err_q;

    // Next-state: lock on a head flit, release and advance the pointer on a tail flit.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        last_gnt_d   = grant_id;
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        if (fire) begin
            if (winner_tail) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = (winner_id == IW'(N_REQ - 1)) ? '0 : winner_id + IW'(1);
            end else begin
                state_d = ARB_LOCKED;
                owner_d = winner_id;
            end
        end
        if (fire && !cr_in) begin
            credits_d = credits_q - CW'(1);
        end else if (cr_in && !fire) begin
            if (credits_q == CW'(DEPTH)) begin
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits_q + CW'(1);
            end
        end
    end

    // State, pointer and credit registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            last_gnt_q   <= '0;
            credits_q    <= CW'(DEPTH);
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            last_gnt_q   <= last_gnt_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
        end
    end

endmodule

// File: tb/tb_inport_arbiter.sv
// Directed bench for inport_arbiter: fairness, packet lock, credit stall, credit error, reset.
`ifndef FLIT_BUFFER_DEPTH
`define FLIT_BUFFER_DEPTH 4
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef VC_BITS
`define VC_BITS 1
`endif

module tb_inport_arbiter;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int W  = 16;
    localparam int PW = W - 2;
    localparam logic [`VC_BITS:0] CR = (`VC_BITS+1)'(1) << `VC_BITS;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [N*W-1:0]   req_flit;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     flit_out;
    logic             en_put;
    logic [`VC_BITS:0] getcr;
    logic             en_getcr;
    logic [1:0]       grant_id;
    logic             locked;
    logic             credit_err;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    inport_arbiter #(.N_REQ(N), .DEPTH(D), .FLIT_W(W)) dut (
        .CLK                        (CLK),
        .RST_N                      (RST_N),
        .req_flit                   (req_flit),
        .req_valid                  (req_valid),
        .req_ready                  (req_ready),
        .send_ports_putFlit_flit_in (flit_out),
        .EN_send_ports_putFlit      (en_put),
        .send_ports_getCredits      (getcr),
        .EN_send_ports_getCredits   (en_getcr),
        .grant_id                   (grant_id),
        .locked                     (locked),
        .credit_err                 (credit_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Requesters drive valid bit 0 so the forced output MSB is observable.
    task automatic set_req(input int i, input logic t, input logic [PW-1:0] p);
        req_flit[i*W +: W] = {1'b0, t, p};
    endtask

    function automatic logic [W-1:0] exp_f(input logic t, input logic [PW-1:0] p);
        return {1'b1, t, p};
    endfunction

    initial begin
        RST_N     = 1'b0;
        req_valid = '0;
        req_flit  = '0;
        getcr     = '0;
        tick();
        tick();

        // Reset gating of the handshake
        req_valid = 4'hF;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, PW'(12'h100 + i));
        #2;
        chk("rst_ready", req_ready, 0);
        chk("rst_en", en_put, 0);
        chk("en_getcr", en_getcr, 1);
        tick();
        RST_N     = 1'b1;
        req_valid = '0;
        #2;
        chk("rst_locked", locked, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_credits", dut.credits_q, D);
        chk("rst_ptr", dut.rr_ptr_q, 0);
        chk("rst_err", credit_err, 0);
        chk("rst_flit", flit_out, 0);
        tick();

        // Round-robin fairness with a credit returned every cycle
        req_valid = 4'hF;
        getcr     = CR;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("rr_grant", grant_id, k % 4);
            chk("rr_ready", req_ready, 1 << (k % 4));
            chk("rr_en", en_put, 1);
            chk("rr_flit", flit_out, exp_f(1'b1, PW'(12'h100 + (k % 4))));
            chk("rr_cred_min", dut.credits_q >= 3, 1);
            tick();
        end
        req_valid = '0;
        getcr     = '0;
        #2;
        chk("rr_ptr_end", dut.rr_ptr_q, 1);
        chk("rr_grant_hold", grant_id, 0);
        chk("rr_en_idle", en_put, 0);
        tick();

        // Packet lock: requester 1 sends 3 flits while requester 0 waits
        req_valid = 4'b0011;
        getcr     = CR;
        set_req(0, 1'b1, 14'h0A0);
        set_req(1, 1'b0, 14'h0B1);
        #2;
        chk("pk_g1", grant_id, 1);
        chk("pk_r1", req_ready, 4'b0010);
        chk("pk_f1", flit_out, exp_f(1'b0, 14'h0B1));
        chk("pk_unlocked", locked, 0);
        tick();
        set_req(1, 1'b0, 14'h0B2);
        #2;
        chk("pk_locked", locked, 1);
        chk("pk_g2", grant_id, 1);
        chk("pk_r2", req_ready, 4'b0010);
        chk("pk_f2", flit_out, exp_f(1'b0, 14'h0B2));
        tick();
        set_req(1, 1'b1, 14'h0B3);
        #2;
        chk("pk_g3", grant_id, 1);
        chk("pk_f3", flit_out, exp_f(1'b1, 14'h0B3));
        tick();
        req_valid = 4'b0001;
        #2;
        chk("pk_release", locked, 0);
        chk("pk_ptr", dut.rr_ptr_q, 2);
        chk("pk_g0", grant_id, 0);
        chk("pk_r0", req_ready, 4'b0001);
        chk("pk_f0", flit_out, exp_f(1'b1, 14'h0A0));
        tick();
        req_valid = '0;
        getcr     = '0;
        #2;
        chk("pk_credits", dut.credits_q, 4);
        chk("pk_ptr2", dut.rr_ptr_q, 1);
        tick();

        // Credit exhaustion: requester 2, 6-flit packet, no credit return
        req_valid = 4'b0100;
        for (int f = 1; f <= 4; f++) begin
            set_req(2, 1'b0, PW'(8'hC0 + f));
            #2;
            chk("ce_ready", req_ready, 4'b0100);
            chk("ce_en", en_put, 1);
            chk("ce_grant", grant_id, 2);
            chk("ce_flit", flit_out, exp_f(1'b0, PW'(8'hC0 + f)));
            tick();
        end
        set_req(2, 1'b0, 14'h0C5);
        #2;
        chk("ce_zero", dut.credits_q, 0);
        chk("ce_stall_ready", req_ready, 0);
        chk("ce_stall_en", en_put, 0);
        chk("ce_stall_locked", locked, 1);
        chk("ce_stall_flit", flit_out, 0);
        tick();
        getcr = CR;
        #2;
        chk("ce_cr_same_cycle", en_put, 0);
        tick();
        getcr = '0;
        #2;
        chk("ce_cred1", dut.credits_q, 1);
        chk("ce_f5_en", en_put, 1);
        chk("ce_f5", flit_out, exp_f(1'b0, 14'h0C5));
        tick();
        set_req(2, 1'b1, 14'h0C6);
        #2;
        chk("ce_stall2", en_put, 0);
        chk("ce_locked2", locked, 1);
        getcr = CR;
        tick();
        getcr = '0;
        #2;
        chk("ce_f6_en", en_put, 1);
        chk("ce_f6", flit_out, exp_f(1'b1, 14'h0C6));
        tick();
        req_valid = '0;
        getcr     = CR;
        #2;
        chk("ce_done", locked, 0);
        chk("ce_ptr", dut.rr_ptr_q, 3);
        chk("ce_cred0", dut.credits_q, 0);
        tick();
        repeat (3) tick();
        getcr = '0;
        #2;
        chk("ce_refill", dut.credits_q, 4);
        tick();

        // Simultaneous fire and credit, then overflow error
        req_valid = 4'b1000;
        set_req(3, 1'b1, 14'h0D3);
        #2;
        chk("sc_g3", grant_id, 3);
        tick();
        req_valid = 4'b0001;
        set_req(0, 1'b1, 14'h0D0);
        #2;
        chk("sc_g0", grant_id, 0);
        tick();
        req_valid = 4'b0010;
        set_req(1, 1'b1, 14'h0D1);
        getcr = CR;
        #2;
        chk("sc_pre", dut.credits_q, 2);
        chk("sc_en", en_put, 1);
        tick();
        req_valid = '0;
        #2;
        chk("sc_same", dut.credits_q, 2);
        tick();
        tick();
        #2;
        chk("sc_full", dut.credits_q, 4);
        chk("sc_err_clear", credit_err, 0);
        tick();
        getcr = '0;
        #2;
        chk("sc_err_set", credit_err, 1);
        chk("sc_sat", dut.credits_q, 4);
        tick();
        tick();
        req_valid = 4'b0100;
        set_req(2, 1'b1, 14'h0E2);
        #2;
        chk("sc_err_sticky", credit_err, 1);
        chk("sc_g2", grant_id, 2);
        tick();
        req_valid = '0;
        #2;
        chk("sc_err_sticky2", credit_err, 1);
        chk("sc_cred3", dut.credits_q, 3);
        chk("sc_ptr", dut.rr_ptr_q, 3);
        tick();

        // Reset in the middle of a 4-flit packet from requester 3
        req_valid = 4'b1000;
        set_req(3, 1'b0, 14'h0F1);
        #2;
        chk("rm_g3", grant_id, 3);
        chk("rm_en1", en_put, 1);
        tick();
        set_req(3, 1'b0, 14'h0F2);
        #2;
        chk("rm_locked", locked, 1);
        chk("rm_en2", en_put, 1);
        tick();
        set_req(3, 1'b0, 14'h0F3);
        RST_N = 1'b0;
        #2;
        chk("rm_rst_ready", req_ready, 0);
        chk("rm_rst_en", en_put, 0);
        tick();
        RST_N     = 1'b1;
        req_valid = '0;
        #2;
        chk("rm_locked0", locked, 0);
        chk("rm_credits", dut.credits_q, D);
        chk("rm_ptr", dut.rr_ptr_q, 0);
        chk("rm_err", credit_err, 0);
        chk("rm_grant", grant_id, 0);
        chk("rm_en", en_put, 0);
        chk("rm_flit", flit_out, 0);
        chk("rm_ready", req_ready, 0);
        tick();
        req_valid = 4'b1001;
        set_req(0, 1'b1, 14'h011);
        set_req(3, 1'b1, 14'h033);
        #2;
        chk("rm_next_g", grant_id, 0);
        chk("rm_next_r", req_ready, 4'b0001);
        chk("rm_next_f", flit_out, exp_f(1'b1, 14'h011));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
